// File: rtl/uart_hexline_pkg.sv
// ============================================================================
// Package : uart_hexline_pkg
// Brief   : Shared types, error codes, ASCII constants and hex decoder for the
//           UART hex-line parser.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_hexline_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DROP    = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  localparam logic [2:0] ERR_BADCHAR  = 3'd0;
  localparam logic [2:0] ERR_ODD      = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW = 3'd2;
  localparam logic [2:0] ERR_BUSY     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;

  // Returns {is_hex, nibble}; nibble is zero for non-hex characters.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [7:0] t;
    logic [4:0] r;
    t = 8'h00;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      r = {1'b1, t[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      t = c - 8'h57;
      r = {1'b1, t[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      r = {1'b1, t[3:0]};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_hexline_parser_if.sv
// ============================================================================
// Interface : uart_hexline_parser_if
// Brief     : Valid/ready frame byte stream with last flag and frame length.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_hexline_parser_if #(
  parameter int LEN_W = 7
);
  logic             valid;
  logic             ready;
  logic [7:0]       data;
  logic             last;
  logic [LEN_W-1:0] len;

  modport master (output valid, output data, output last, output len, input ready);
  modport slave  (input valid, input data, input last, input len, output ready);
endinterface

`default_nettype wire

// File: rtl/hexline_buf.sv
// ============================================================================
// Module : hexline_buf
// Brief  : MAX_LEN x 8 frame buffer, one write port, asynchronous read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hexline_buf #(
  parameter int MAX_LEN = 64,
  parameter int AW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  // Address compare per entry keeps the index width independent of MAX_LEN.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (waddr_i == AW'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (raddr_i == AW'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_hexline_parser.sv
// ============================================================================
// Module : uart_hexline_parser
// Brief  : Parses ASCII hex command lines from a UART byte strobe into framed
//          byte bursts. Optional idle timeout: UART_HEXLINE_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_hexline_parser
  import uart_hexline_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 12500000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         rx_byte_en_i,
  input  logic [7:0]                   rx_byte_i,
  uart_hexline_parser_if.master        out_if,
  output logic                         err_pulse_o,
  output logic [2:0]                   err_code_o
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);

  if (MAX_LEN < 2 || MAX_LEN > 256 || TIMEOUT < 1) begin : g_param_check
    $error("uart_hexline_parser: parameter out of range");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] len_q, len_d;
  logic          pend_q, pend_d;
  logic [3:0]    hi_q, hi_d;
  logic          drop_pend_q, drop_pend_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;

  logic [4:0]    dec;
  logic          is_term, is_sep;
  logic          wr_en, drop_next, last_beat;
  logic [7:0]    rd_data;

`ifdef UART_HEXLINE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
  logic [31:0] idle_q, idle_d;
`endif

  assign dec     = hex_decode(rx_byte_i);
  assign is_term = (rx_byte_i == CH_CR) || (rx_byte_i == CH_LF);
  assign is_sep  = (rx_byte_i == CH_SP) || (rx_byte_i == CH_TAB);

  hexline_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (CW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (count_q),
    .wdata_i ({hi_q, dec[3:0]}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign last_beat    = (rd_ptr_q == len_q - CW'(1));
  assign out_if.valid = (state_q == S_OUTPUT);
  assign out_if.data  = out_if.valid ? rd_data : 8'h00;
  assign out_if.last  = out_if.valid && last_beat;
  assign out_if.len   = len_q;
  assign err_pulse_o  = err_q;
  assign err_code_o   = code_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    pend_d      = pend_q;
    hi_d        = hi_q;
    drop_pend_d = drop_pend_q;
    err_d       = 1'b0;
    code_d      = code_q;
    wr_en       = 1'b0;
    drop_next   = drop_pend_q;

    unique case (state_q)
      S_COLLECT: begin
        if (rx_byte_en_i) begin
          if (dec[4]) begin
            if (!pend_q) begin
              hi_d   = dec[3:0];
              pend_d = 1'b1;
            end else if (count_q == MAX_C) begin
              err_d   = 1'b1;
              code_d  = ERR_OVERFLOW;
              state_d = S_DROP;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + CW'(1);
              pend_d  = 1'b0;
            end
          end else if (is_sep) begin
            if (pend_q) begin
              err_d   = 1'b1;
              code_d  = ERR_BADCHAR;
              state_d = S_DROP;
            end
          end else if (is_term) begin
            if (pend_q) begin
              err_d   = 1'b1;
              code_d  = ERR_ODD;
              count_d = '0;
              pend_d  = 1'b0;
            end else if (count_q != '0) begin
              state_d  = S_OUTPUT;
              len_d    = count_q;
              rd_ptr_d = '0;
            end
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BADCHAR;
            state_d = S_DROP;
          end
        end
      end

      S_DROP: begin
        if (rx_byte_en_i && is_term) begin
          state_d = S_COLLECT;
          count_d = '0;
          pend_d  = 1'b0;
        end
      end

      S_OUTPUT: begin
        // A strobe here cannot be buffered; remember whether its line continues.
        if (rx_byte_en_i) begin
          err_d     = 1'b1;
          code_d    = ERR_BUSY;
          drop_next = !is_term;
        end
        drop_pend_d = drop_next;
        if (out_if.ready) begin
          if (last_beat) begin
            rd_ptr_d    = '0;
            count_d     = '0;
            pend_d      = 1'b0;
            drop_pend_d = 1'b0;
            state_d     = drop_next ? S_DROP : S_COLLECT;
          end else begin
            rd_ptr_d = rd_ptr_q + CW'(1);
          end
        end
      end

      default: state_d = S_COLLECT;
    endcase

`ifdef UART_HEXLINE_TIMEOUT_EN
    idle_d = idle_q;
    if (rx_byte_en_i) begin
      idle_d = '0;
    end else if ((state_q == S_COLLECT && (count_q != '0 || pend_q)) ||
                 state_q == S_DROP) begin
      if (idle_q >= TIMEOUT_C - 32'd1) begin
        idle_d  = '0;
        count_d = '0;
        pend_d  = 1'b0;
        state_d = S_COLLECT;
        if (state_q == S_COLLECT) begin
          err_d  = 1'b1;
          code_d = ERR_TIMEOUT;
        end
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end else begin
      idle_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_COLLECT;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      pend_q      <= 1'b0;
      hi_q        <= 4'h0;
      drop_pend_q <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      pend_q      <= pend_d;
      hi_q        <= hi_d;
      drop_pend_q <= drop_pend_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

`ifdef UART_HEXLINE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_hexline_parser.sv
// ============================================================================
// Module : tb_uart_hexline_parser
// Brief  : Scoreboard bench: line-level reference model feeds expected beats
//          and error codes; a negedge monitor pops and compares.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_hexline_parser;

  localparam int MAX_LEN = 4;
  localparam int TIMEOUT = 100;
  localparam int LW      = $clog2(MAX_LEN + 1);

  localparam int E_BAD = 0, E_ODD = 1, E_OVF = 2, E_BUSY = 3, E_TMO = 4;

  typedef struct {
    int d;
    bit last;
    int len;
  } beat_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_en = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       err_pulse;
  logic [2:0] err_code;

  beat_t exp_q[$];
  int    err_q[$];
  beat_t head;
  int    checks = 0;
  int    failures = 0;
  int    ready_mode = 0;

  always #5 clk = ~clk;

  uart_hexline_parser_if #(.LEN_W(LW)) bus ();

  uart_hexline_parser #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_byte_en_i (rx_en),
    .rx_byte_i    (rx_byte),
    .out_if       (bus),
    .err_pulse_o  (err_pulse),
    .err_code_o   (err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready: 0 = random, 1 = held low, 2 = held high
  initial begin
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.ready = 1'b0;
        2:       bus.ready = 1'b1;
        default: bus.ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          if (bus.ready) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: data 0x%0h with no beat expected", bus.data);
          end
        end else begin
          head = exp_q[0];
          check("out_data", 32'(bus.data), 32'(head.d));
          check("out_last", 32'(bus.last), 32'(head.last));
          check("out_len", 32'(bus.len), 32'(head.len));
          if (bus.ready) void'(exp_q.pop_front());
        end
      end
      if (err_pulse) begin
        if (err_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_err: code %0d with no error expected", err_code);
        end else begin
          check("err_code", 32'(err_code), 32'(err_q.pop_front()));
        end
      end
    end
  end

  function automatic int hexval(input int c);
    if (c >= 48 && c <= 57)  return c - 48;
    if (c >= 97 && c <= 102) return c - 87;
    if (c >= 65 && c <= 70)  return c - 55;
    return -1;
  endfunction

  // One segment = characters up to and including a single terminator.
  function automatic void model_seg(input string seg);
    int nib[$];
    bit dead = 1'b0;
    int n;
    for (int i = 0; i < seg.len(); i++) begin
      int c = int'(seg[i]);
      if (c == 13 || c == 10) begin
        if (!dead) begin
          n = nib.size();
          if (n % 2 == 1) err_q.push_back(E_ODD);
          else begin
            for (int k = 0; k < n / 2; k++) begin
              beat_t b;
              b.d    = nib[2*k] * 16 + nib[2*k+1];
              b.last = (k == n / 2 - 1);
              b.len  = n / 2;
              exp_q.push_back(b);
            end
          end
        end
        return;
      end
      if (dead) continue;
      if (hexval(c) >= 0) begin
        nib.push_back(hexval(c));
        if (nib.size() % 2 == 0 && nib.size() / 2 > MAX_LEN) begin
          err_q.push_back(E_OVF);
          dead = 1'b1;
        end
      end else if (c == 32 || c == 9) begin
        if (nib.size() % 2 == 1) begin
          err_q.push_back(E_BAD);
          dead = 1'b1;
        end
      end else begin
        err_q.push_back(E_BAD);
        dead = 1'b1;
      end
    end
  endfunction

  task automatic send_char(input logic [7:0] c, input int gap);
    @(posedge clk);
    #1;
    rx_en   = 1'b1;
    rx_byte = c;
    @(posedge clk);
    #1;
    rx_en = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL drain_timeout: %0d beats and %0d errors still outstanding",
               exp_q.size(), err_q.size());
      exp_q.delete();
      err_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_line(input string s);
    string seg = "";
    for (int i = 0; i < s.len(); i++) begin
      seg = {seg, s.substr(i, i)};
      if (s[i] == 8'h0D || s[i] == 8'h0A) begin
        model_seg(seg);
        for (int j = 0; j < seg.len(); j++) send_char(seg[j], $urandom_range(0, 3));
        wait_drain();
        seg = "";
      end
    end
  endtask

  function automatic string rand_line();
    string s = "";
    string p;
    string bads = "G#z!-.";
    int nb = $urandom_range(1, MAX_LEN + 1);
    int kind = $urandom_range(0, 7);
    for (int k = 0; k < nb; k++) begin
      if ($urandom_range(0, 1) != 0) p = $sformatf("%02x", $urandom_range(0, 255));
      else                           p = $sformatf("%02X", $urandom_range(0, 255));
      if (kind == 2 && k == 0) p = p.substr(0, 0);
      if (kind == 3 && k == 0) p = {p.substr(0, 0), " ", p.substr(1, 1)};
      s = {s, p};
      if ($urandom_range(0, 2) == 0) s = {s, ($urandom_range(0, 1) != 0) ? " " : "\t"};
    end
    if (kind == 1)
      s = {s.substr(0, 0), $sformatf("%c", bads[$urandom_range(0, 5)]), s.substr(1, s.len() - 1)};
    case ($urandom_range(0, 2))
      0:       s = {s, "\n"};
      1:       s = {s, "\r"};
      default: s = {s, "\r\n"};
    endcase
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string busy = "0102\n";
    string rst_line = "0a0b\n";
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(bus.valid), 0);
    check("reset_last", 32'(bus.last), 0);
    check("reset_data", 32'(bus.data), 0);
    check("reset_len", 32'(bus.len), 0);
    check("reset_err_pulse", 32'(err_pulse), 0);
    check("reset_err_code", 32'(err_code), 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    ready_mode = 2;
    run_line("26\n");
    ready_mode = 0;
    run_line("93 20\r\n");
    run_line("9G20\n52\n");
    run_line("123\nab\n");
    run_line("0102030405\nff\n");

    // Busy: hold the frame, strobe another line into S_OUTPUT.
    ready_mode = 1;
    @(posedge clk);
    model_seg(busy);
    for (int j = 0; j < busy.len(); j++) send_char(busy[j], (j == busy.len() - 1) ? 0 : 1);
    @(negedge clk);
    check("valid_latency", 32'(bus.valid), 1);
    repeat (3) err_q.push_back(E_BUSY);
    send_char(8'h33, 1);
    send_char(8'h33, 1);
    send_char(8'h0A, 1);
    ready_mode = 0;
    wait_drain();
    run_line("44\n");

    // Reset while a frame is held.
    ready_mode = 1;
    @(posedge clk);
    model_seg(rst_line);
    for (int j = 0; j < rst_line.len(); j++) send_char(rst_line[j], 1);
    n = 0;
    while (!bus.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_before_reset", 32'(bus.valid), 1);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    err_q.delete();
    @(negedge clk);
    check("midframe_reset_valid", 32'(bus.valid), 0);
    check("midframe_reset_len", 32'(bus.len), 0);
    rstn = 1'b1;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    run_line("0c\n");

`ifdef UART_HEXLINE_TIMEOUT_EN
    err_q.push_back(E_TMO);
    send_char(8'h31, 0);
    repeat (TIMEOUT + 5) @(posedge clk);
    wait_drain();
    run_line("5a\n");
`endif

    for (int r = 0; r < 40; r++) run_line(rand_line());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
